// File: rtl/stepper_driver_if.sv
// Move-command channel between an axis controller and stepper_driver:
// step count and direction, qualified by a valid/ready handshake.
interface stepper_driver_if #(
   parameter int POS_WIDTH = 16
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [POS_WIDTH-1:0] cmd_steps;
   logic                 cmd_dir;

   modport master (output cmd_valid, cmd_steps, cmd_dir, input cmd_ready);
   modport slave  (input cmd_valid, cmd_steps, cmd_dir, output cmd_ready);
endinterface

// File: rtl/stepper_driver.sv
// Turns rate-generator step strobes into fixed-width STEP pulses with DIR setup,
// executing one counted move at a time and tracking signed absolute position.
module stepper_driver #(
   parameter int POS_WIDTH         = 16,
   parameter int STEP_PULSE_CYCLES = 200,
   parameter int DIR_SETUP_CYCLES  = 100
) (
   input  logic                        clk_100mhz,
   input  logic                        rst_n,
   input  logic                        enable_step,
   stepper_driver_if.slave             cmd,
   input  logic                        abort,
   output logic                        step,
   output logic                        dir,
   output logic                        busy,
   output logic                        done,
   output logic        [POS_WIDTH-1:0] steps_remaining,
   output logic signed [POS_WIDTH-1:0] position
);

   localparam int CNT_MAX = (STEP_PULSE_CYCLES > DIR_SETUP_CYCLES) ? STEP_PULSE_CYCLES
                                                                    : DIR_SETUP_CYCLES;
   // The shared counter only ever holds a load value of (cycles - 1).
   localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(DIR_SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(STEP_PULSE_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_WAIT, ST_PULSE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             abort_pend;

   // Two's-complement wrap is the intended behaviour at both extremes.
   function automatic logic signed [POS_WIDTH-1:0] advance_position(
      input logic signed [POS_WIDTH-1:0] pos,
      input logic                        fwd
   );
      return fwd ? pos + POS_WIDTH'(1) : pos - POS_WIDTH'(1);
   endfunction

   assign cmd.cmd_ready = (state == ST_IDLE);
   assign busy          = (state != ST_IDLE);

   always_ff @(posedge clk_100mhz) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         abort_pend      <= 1'b0;
         step            <= 1'b0;
         dir             <= 1'b0;
         done            <= 1'b0;
         steps_remaining <= '0;
         position        <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               abort_pend <= 1'b0;
               if (cmd.cmd_valid) begin
                  if (cmd.cmd_steps == '0) begin
                     done <= 1'b1;
                  end else begin
                     dir             <= cmd.cmd_dir;
                     steps_remaining <= cmd.cmd_steps;
                     cnt             <= SETUP_LOAD;
                     state           <= ST_SETUP;
                  end
               end
            end
            ST_SETUP: begin
               if (abort) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end else if (cnt == '0) begin
                  state <= ST_WAIT;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_WAIT: begin
               // Abort takes priority over a coincident strobe.
               if (abort) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end else if (enable_step) begin
                  step            <= 1'b1;
                  steps_remaining <= steps_remaining - POS_WIDTH'(1);
                  position        <= advance_position(position, dir);
                  cnt             <= PULSE_LOAD;
                  state           <= ST_PULSE;
               end
            end
            ST_PULSE: begin
               if (abort) abort_pend <= 1'b1;
               if (cnt == '0) begin
                  step <= 1'b0;
                  if (abort_pend || abort || steps_remaining == '0) begin
                     abort_pend <= 1'b0;
                     done       <= 1'b1;
                     state      <= ST_IDLE;
                  end else begin
                     state <= ST_WAIT;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stepper_driver.sv
// Directed bench for stepper_driver: expected step/done events are queued when
// stimulus is driven and checked by a monitor when the DUT produces them.
module tb_stepper_driver;
   localparam int PW  = 16;
   localparam int SPC = 4;
   localparam int DSC = 3;

   logic                 clk_100mhz  = 1'b0;
   logic                 rst_n       = 1'b0;
   logic                 enable_step = 1'b0;
   logic                 abort       = 1'b0;
   logic                 step, dir, busy, done;
   logic        [PW-1:0] steps_remaining;
   logic signed [PW-1:0] position;

   stepper_driver_if #(.POS_WIDTH(PW)) cmd ();

   stepper_driver #(
      .POS_WIDTH(PW), .STEP_PULSE_CYCLES(SPC), .DIR_SETUP_CYCLES(DSC)
   ) dut (
      .clk_100mhz(clk_100mhz), .rst_n(rst_n), .enable_step(enable_step), .cmd(cmd),
      .abort(abort), .step(step), .dir(dir), .busy(busy), .done(done),
      .steps_remaining(steps_remaining), .position(position)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   typedef struct packed {
      logic [PW-1:0] pos;
      logic [PW-1:0] rem;
   } step_exp_t;

   step_exp_t     exp_step[$];
   logic [PW-1:0] exp_done[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   logic          skip_width = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic push_step(input logic [PW-1:0] p, input logic [PW-1:0] r);
      step_exp_t e;
      e.pos = p;
      e.rem = r;
      exp_step.push_back(e);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk_100mhz);
      #1;
   endtask

   task automatic accept(input logic [PW-1:0] steps, input logic d);
      check("cmd_ready_pre", cmd.cmd_ready, 1);
      cmd.cmd_valid = 1'b1;
      cmd.cmd_steps = steps;
      cmd.cmd_dir   = d;
      wait_cycles(1);
      cmd.cmd_valid = 1'b0;
      cmd.cmd_steps = '0;
   endtask

   task automatic strobe();
      enable_step = 1'b1;
      wait_cycles(1);
      enable_step = 1'b0;
   endtask

   // Monitor: pulse rises consume a queued step, done pulses consume a queued done.
   logic      prev_step = 1'b0;
   logic      prev_done = 1'b0;
   int        high_cnt  = 0;
   step_exp_t mon_e;
   always @(negedge clk_100mhz) begin
      if (step === 1'b1 && prev_step !== 1'b1) begin
         check("step_expected", 32'(exp_step.size() != 0), 1);
         if (exp_step.size() != 0) begin
            mon_e = exp_step.pop_front();
            check("step_position", 32'($unsigned(position)), 32'(mon_e.pos));
            check("step_remaining", 32'(steps_remaining), 32'(mon_e.rem));
         end
         high_cnt = 1;
      end else if (step === 1'b1) begin
         high_cnt++;
      end else if (prev_step === 1'b1 && !skip_width) begin
         check("pulse_width", high_cnt, SPC);
      end
      if (done === 1'b1) begin
         check("done_vs_step", step, 0);
         check("done_width", prev_done, 0);
         check("done_expected", 32'(exp_done.size() != 0), 1);
         if (exp_done.size() != 0) check("done_remaining", 32'(steps_remaining), 32'(exp_done.pop_front()));
      end
      prev_step = step;
      prev_done = done;
   end

   initial begin
      cmd.cmd_valid = 1'b0;
      cmd.cmd_steps = '0;
      cmd.cmd_dir   = 1'b0;

      // Reset held with random inputs
      rst_n = 1'b0;
      repeat (3) begin
         cmd.cmd_valid = 1'($urandom_range(0, 1));
         cmd.cmd_steps = PW'($urandom);
         cmd.cmd_dir   = 1'($urandom_range(0, 1));
         enable_step   = 1'($urandom_range(0, 1));
         abort         = 1'($urandom_range(0, 1));
         wait_cycles(1);
      end
      check("rst_step", step, 0);
      check("rst_dir", dir, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_remaining", 32'(steps_remaining), 0);
      check("rst_position", 32'($unsigned(position)), 0);
      check("rst_cmd_ready", cmd.cmd_ready, 1);
      cmd.cmd_valid = 1'b0;
      cmd.cmd_steps = '0;
      cmd.cmd_dir   = 1'b0;
      enable_step   = 1'b0;
      abort         = 1'b0;
      rst_n         = 1'b1;
      wait_cycles(2);

      // Normal forward move of 3 steps, strobe every 20 cycles
      accept(3, 1'b1);
      check("fwd_busy", busy, 1);
      check("fwd_dir", dir, 1);
      check("fwd_remaining", 32'(steps_remaining), 3);
      for (int k = 1; k <= 3; k++) begin
         wait_cycles(19);
         push_step(PW'(k), PW'(3 - k));
         if (k == 3) exp_done.push_back('0);
         strobe();
      end
      wait_cycles(3);
      check("fwd_last_step_high", step, 1);
      check("fwd_done_early", done, 0);
      wait_cycles(1);
      check("fwd_step_low", step, 0);
      check("fwd_done", done, 1);
      check("fwd_busy_end", busy, 0);
      check("fwd_ready_end", cmd.cmd_ready, 1);
      check("fwd_position", 32'($unsigned(position)), 3);

      // Reverse move: strobe during SETUP and mid-PULSE are dropped
      wait_cycles(5);
      accept(3, 1'b0);
      strobe();
      check("setup_strobe_dropped", step, 0);
      check("setup_remaining", 32'(steps_remaining), 3);
      wait_cycles(5);
      push_step(2, 2);
      strobe();
      wait_cycles(1);
      strobe();
      check("pulse_strobe_position", 32'($unsigned(position)), 2);
      wait_cycles(10);
      check("pulse_strobe_remaining", 32'(steps_remaining), 2);
      push_step(1, 1);
      strobe();
      wait_cycles(10);
      push_step(0, 0);
      exp_done.push_back('0);
      strobe();
      wait_cycles(10);
      check("rev_position", 32'($unsigned(position)), 0);
      check("rev_dir", dir, 0);
      check("rev_busy", busy, 0);

      // Reverse through zero; earliest honoured strobe right after setup
      accept(2, 1'b0);
      check("wrap_dir", dir, 0);
      check("wrap_pos_before", 32'($unsigned(position)), 0);
      wait_cycles(2);
      strobe();
      push_step(16'hFFFF, 1);
      strobe();
      wait_cycles(10);
      push_step(16'hFFFE, 0);
      exp_done.push_back('0);
      strobe();
      wait_cycles(10);
      check("wrap_position", 32'($unsigned(position)), 32'hFFFE);

      // Zero-length move
      exp_done.push_back('0);
      accept(0, 1'b1);
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      check("zero_dir", dir, 0);
      check("zero_position", 32'($unsigned(position)), 32'hFFFE);
      wait_cycles(1);
      check("zero_done_cleared", done, 0);

      // Abort coinciding with a strobe in WAIT
      wait_cycles(2);
      accept(3, 1'b1);
      wait_cycles(6);
      push_step(16'hFFFF, 2);
      strobe();
      wait_cycles(10);
      exp_done.push_back(2);
      abort       = 1'b1;
      enable_step = 1'b1;
      wait_cycles(1);
      abort       = 1'b0;
      enable_step = 1'b0;
      check("abw_step", step, 0);
      check("abw_done", done, 1);
      check("abw_busy", busy, 0);
      check("abw_remaining", 32'(steps_remaining), 2);
      check("abw_position", 32'($unsigned(position)), 32'hFFFF);

      // Abort mid-PULSE: full-width pulse, then done
      wait_cycles(2);
      accept(2, 1'b1);
      wait_cycles(6);
      push_step(16'h0000, 1);
      exp_done.push_back(1);
      strobe();
      wait_cycles(1);
      abort = 1'b1;
      wait_cycles(1);
      abort = 1'b0;
      wait_cycles(1);
      check("abp_step_held", step, 1);
      check("abp_done_early", done, 0);
      wait_cycles(1);
      check("abp_step_low", step, 0);
      check("abp_done", done, 1);
      check("abp_busy", busy, 0);
      check("abp_remaining", 32'(steps_remaining), 1);

      // Reset mid-PULSE: step drops at once, no done
      wait_cycles(2);
      accept(2, 1'b1);
      wait_cycles(6);
      push_step(16'h0001, 1);
      strobe();
      skip_width = 1'b1;
      rst_n      = 1'b0;
      wait_cycles(1);
      check("rstp_step", step, 0);
      check("rstp_done", done, 0);
      check("rstp_busy", busy, 0);
      check("rstp_position", 32'($unsigned(position)), 0);
      check("rstp_remaining", 32'(steps_remaining), 0);
      rst_n = 1'b1;
      wait_cycles(8);
      skip_width = 1'b0;
      check("rstp_no_done", done, 0);

      check("step_queue_drained", 32'(exp_step.size()), 0);
      check("done_queue_drained", 32'(exp_done.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
